pdp11_trace_buffer: RTL and testbench
=====================================

Name: pdp11_trace_buffer

Overview:
- Synthesisable, parametrised instruction-trace capture unit for the PDP-11 core; replaces the print-only state monitor with on-chip history.
- Taps the decode (S2) and execute (S3) stages and assembles one record per retired instruction: {PC, instruction word, ALU result}.
- Stores records in a circular buffer with free-run, stop-when-full and PC-trigger modes.
- Raises a halt request on an unrecognised instruction, then freezes the buffer for indexed readout.

Parameters:
DEPTH, 16, record slots; power of two, >= 2
PC_W, 16, program counter width
INS_W, 16, instruction word width
DATA_W, 16, ALU result width
POST_TRIG, 4, records captured after trigger before freeze; 0..DEPTH-1

Ports:
clk  in  1  core clock
reset_n  in  1  synchronous active-low reset
arm  in  1  single-cycle pulse; clears buffer and starts capture
mode  in  2  0=free-run wrap, 1=stop-when-full, 2=PC trigger, 3=reserved (treated as 0)
trig_pc  in  PC_W  trigger address for mode 2
decode_valid  in  1  S2 entered this cycle
decode_pc  in  PC_W  PC of decoded instruction
decode_instr  in  INS_W  instruction word
decode_known  in  1  decoder matched a valid instruction type
exec_valid  in  1  S3 entered this cycle
exec_result  in  DATA_W  ALU output
rd_en  in  1  readout request; honoured only in FROZEN
rd_idx  in  $clog2(DEPTH)  0 = oldest record
rd_valid  out  1  read data valid
rd_pc  out  PC_W  read record PC
rd_instr  out  INS_W  read record instruction
rd_result  out  DATA_W  read record result
fill_count  out  $clog2(DEPTH)+1  valid records, saturates at DEPTH
instr_count  out  32  records committed since arm, wraps at 2^32
triggered  out  1  trigger seen since arm
halt_req  out  1  sticky halt request to core
state_o  out  2  0=IDLE, 1=CAPTURE, 2=POST, 3=FROZEN

Behaviour:
- Reset (reset_n low at posedge):
  - State IDLE.
  - All outputs 0; wr_ptr=0; pending record cleared.
  - Buffer contents need not be cleared.
  - Reset mid-capture or mid-readout aborts immediately, with no partial commit.
- Pending record:
  - decode_valid loads pc/instr into pending and sets pending_v.
  - A second decode without an intervening exec overwrites pending.
- Commit:
  - exec_valid with pending_v writes {pending, exec_result} at wr_ptr.
  - wr_ptr increments modulo DEPTH; fill_count increments, saturating at DEPTH; instr_count increments; pending_v clears.
  - exec_valid with pending_v=0 is ignored.
  - decode_valid and exec_valid in the same cycle: commit the old pending, then load the new one.
- Commits occur only in CAPTURE or POST.
- State machine:
  - IDLE: arm -> CAPTURE (clear wr_ptr, fill_count, instr_count, triggered, halt_req, pending_v).
  - CAPTURE, mode 0: wraps indefinitely, overwriting the oldest record; leaves only on halt or arm.
  - CAPTURE, mode 1: the commit that makes fill_count=DEPTH -> FROZEN the next cycle. Further exec ignored.
  - CAPTURE, mode 2: on the commit of a record whose PC == trig_pc, set triggered.
    - POST_TRIG=0 -> FROZEN.
    - Otherwise -> POST, with post_cnt=POST_TRIG.
  - POST: each commit decrements post_cnt; at 0 -> FROZEN. Trigger matches in POST are ignored.
  - FROZEN: no commits. arm -> CAPTURE with a full clear, as from IDLE.
  - arm in CAPTURE or POST restarts capture with a full clear.
- Halt:
  - decode_valid && !decode_known && decode_pc != 0 in CAPTURE or POST sets halt_req (sticky until arm or reset).
  - The faulting record is committed immediately with result 0.
  - State -> FROZEN the next cycle, regardless of mode.
  - An unknown instruction at PC 0 is not a halt; it is recorded normally.
- Readout:
  - rd_en in FROZEN: next cycle rd_valid=1 with the record at physical index (oldest + rd_idx) mod DEPTH.
  - oldest = 0 if fill_count < DEPTH, else wr_ptr.
  - rd_idx >= fill_count returns all-zero data with rd_valid=1.
  - rd_en outside FROZEN: rd_valid stays 0.
  - Latency is 1 cycle; back-to-back reads give one result per cycle.
- Widths:
  - fill_count saturates at DEPTH.
  - instr_count wraps at 2^32.
  - PC compare is full PC_W equality.

Test Plan:
1. Mode 1, DEPTH=4, arm, six decode/exec pairs with PC 0o1000,0o1002,... -> FROZEN after the 4th commit; fill_count=4; rd_idx 0..3 return PCs 0o1000..0o1006; instr_count=4.
2. Mode 0, DEPTH=4, ten commits, then force a halt via decode_known=0 at PC 0o2000 -> halt_req=1; FROZEN; fill_count=4; rd_idx 3 returns PC 0o2000 with result 0; rd_idx 0 returns the 8th committed PC.
3. Mode 2, trig_pc=0o1010, POST_TRIG=2, sequential PCs from 0o1000 -> triggered at 0o1010; FROZEN after 0o1014; the newest record is PC 0o1014.
4. Same-cycle decode(PC 0o1004) and exec(result 7) with pending PC 0o1002 -> record {0o1002, result 7} committed; pending holds 0o1004.
5. reset_n low for one cycle mid-POST -> next cycle state_o=0, all outputs 0; a following arm restarts cleanly with fill_count=0.
6. exec_valid without a prior decode, and unknown instruction at PC 0 -> no commit in the first case; in the second, the record is stored and halt_req stays 0.

Source files
------------

// File: rtl/pdp11_trace_buffer.sv
// pdp11_trace_buffer: instruction-trace capture unit for the PDP-11 core.
// Joins the decode stage (S2) to the execute stage (S3) to form one record
// {PC, instruction word, ALU result} for each retired instruction. Records go
// into a circular buffer, which freezes for indexed readout.
// Ports:
//   clk, reset_n           core clock, synchronous active-low reset
//   arm, mode, trig_pc     capture control (free-run / stop-when-full / PC trigger)
//   decode_*               S2 tap: pc, instruction, known-opcode flag
//   exec_valid/_result     S3 tap: ALU result that completes the pending record
//   rd_en, rd_idx          readout request (FROZEN only), index 0 = oldest
//   rd_valid/pc/instr/result  readout data, one cycle after rd_en
//   fill_count, instr_count, triggered, halt_req, state_o  status
module pdp11_trace_buffer #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned PC_W      = 16,
    parameter int unsigned INS_W     = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned POST_TRIG = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     arm,
    input  logic [1:0]               mode,
    input  logic [PC_W-1:0]          trig_pc,
    input  logic                     decode_valid,
    input  logic [PC_W-1:0]          decode_pc,
    input  logic [INS_W-1:0]         decode_instr,
    input  logic                     decode_known,
    input  logic                     exec_valid,
    input  logic [DATA_W-1:0]        exec_result,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic                     rd_valid,
    output logic [PC_W-1:0]          rd_pc,
    output logic [INS_W-1:0]         rd_instr,
    output logic [DATA_W-1:0]        rd_result,
    output logic [$clog2(DEPTH):0]   fill_count,
    output logic [31:0]              instr_count,
    output logic                     triggered,
    output logic                     halt_req,
    output logic [1:0]               state_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;
    localparam int unsigned RW = PC_W + INS_W + DATA_W;
    localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);
    localparam logic [FW-1:0] FULL      = FW'(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_POST    = 2'd2;
    localparam logic [1:0] S_FROZEN  = 2'd3;

    logic [RW-1:0]     mem [DEPTH];

    logic [1:0]        state_d;
    logic [AW-1:0]     wr_ptr, wr_ptr_d;
    logic [AW-1:0]     post_cnt, post_cnt_d;
    logic [FW-1:0]     fill_d, fill_sum;
    logic [31:0]       icnt_d;
    logic              trig_d, halt_d;
    logic              pend_v, pend_v_d;
    logic [PC_W-1:0]   pend_pc, pend_pc_d;
    logic [INS_W-1:0]  pend_ins, pend_ins_d;

    logic              active, c_pend, c_halt, trig_hit;
    logic [1:0]        n_commit;
    logic [AW-1:0]     halt_addr;
    logic [AW-1:0]     oldest, rd_addr;
    logic              rd_valid_d;
    logic [RW-1:0]     rd_rec_d;

    // Commit qualification; an arm cycle never commits.
    always_comb begin
        active    = ((state_o == S_CAPTURE) || (state_o == S_POST)) && !arm;
        c_pend    = active && exec_valid && pend_v;
        c_halt    = active && decode_valid && !decode_known && (decode_pc != '0);
        n_commit  = {1'b0, c_pend} + {1'b0, c_halt};
        // Pending record is older than the faulting one, so it takes the lower slot.
        halt_addr = c_pend ? (wr_ptr + AW'(1)) : wr_ptr;
        fill_sum  = fill_count + FW'(n_commit);
        trig_hit  = (mode == 2'd2) && (state_o == S_CAPTURE) &&
                    ((c_pend && (pend_pc == trig_pc)) ||
                     (c_halt && (decode_pc == trig_pc)));
    end

    // Next-state and counter logic.
    always_comb begin
        state_d    = state_o;
        wr_ptr_d   = wr_ptr + AW'(n_commit);
        fill_d     = (fill_sum > FULL) ? FULL : fill_sum;
        icnt_d     = instr_count + 32'(n_commit);
        trig_d     = triggered | trig_hit;
        halt_d     = halt_req | c_halt;
        post_cnt_d = post_cnt;
        pend_v_d   = pend_v;
        pend_pc_d  = pend_pc;
        pend_ins_d = pend_ins;

        // Faulting instruction is committed directly, so it never becomes pending.
        if (c_halt) begin
            pend_v_d = 1'b0;
        end else if (decode_valid) begin
            pend_v_d   = 1'b1;
            pend_pc_d  = decode_pc;
            pend_ins_d = decode_instr;
        end else if (c_pend) begin
            pend_v_d = 1'b0;
        end

        case (state_o)
            S_CAPTURE: begin
                if (c_halt) begin
                    state_d = S_FROZEN;
                end else if ((mode == 2'd1) && (n_commit != 2'd0) && (fill_d == FULL)) begin
                    state_d = S_FROZEN;
                end else if (trig_hit) begin
                    state_d    = (POST_INIT == '0) ? S_FROZEN : S_POST;
                    post_cnt_d = POST_INIT;
                end
            end
            S_POST: begin
                if (c_halt) begin
                    state_d = S_FROZEN;
                end else if (c_pend) begin
                    post_cnt_d = post_cnt - AW'(1);
                    if (post_cnt == AW'(1)) state_d = S_FROZEN;
                end
            end
            default: state_d = state_o;
        endcase

        if (arm) begin
            state_d    = S_CAPTURE;
            wr_ptr_d   = '0;
            fill_d     = '0;
            icnt_d     = '0;
            trig_d     = 1'b0;
            halt_d     = 1'b0;
            post_cnt_d = '0;
            pend_v_d   = 1'b0;
        end
    end

    // Readout address: logical index relative to the oldest live record.
    always_comb begin
        oldest     = (fill_count == FULL) ? wr_ptr : '0;
        rd_addr    = oldest + rd_idx;
        rd_valid_d = (state_o == S_FROZEN) && rd_en;
        rd_rec_d   = '0;
        if (rd_valid_d && ({1'b0, rd_idx} < fill_count)) rd_rec_d = mem[rd_addr];
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_o     <= S_IDLE;
            wr_ptr      <= '0;
            post_cnt    <= '0;
            fill_count  <= '0;
            instr_count <= '0;
            triggered   <= 1'b0;
            halt_req    <= 1'b0;
            pend_v      <= 1'b0;
            pend_pc     <= '0;
            pend_ins    <= '0;
            rd_valid    <= 1'b0;
            rd_pc       <= '0;
            rd_instr    <= '0;
            rd_result   <= '0;
        end else begin
            state_o     <= state_d;
            wr_ptr      <= wr_ptr_d;
            post_cnt    <= post_cnt_d;
            fill_count  <= fill_d;
            instr_count <= icnt_d;
            triggered   <= trig_d;
            halt_req    <= halt_d;
            pend_v      <= pend_v_d;
            pend_pc     <= pend_pc_d;
            pend_ins    <= pend_ins_d;
            rd_valid    <= rd_valid_d;
            rd_pc       <= rd_rec_d[RW-1 -: PC_W];
            rd_instr    <= rd_rec_d[DATA_W +: INS_W];
            rd_result   <= rd_rec_d[DATA_W-1:0];
        end
    end

    // Record storage; reset suppresses any commit in that cycle.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (c_pend) mem[wr_ptr]    <= {pend_pc, pend_ins, exec_result};
            if (c_halt) mem[halt_addr] <= {decode_pc, decode_instr, {DATA_W{1'b0}}};
        end
    end

endmodule

// File: tb/tb_pdp11_trace_buffer.sv
// Directed bench for pdp11_trace_buffer (DEPTH=4, POST_TRIG=2).
module tb_pdp11_trace_buffer;

    localparam logic [15:0] KNOWN = 16'o010102;
    localparam logic [15:0] BAD   = 16'o000010;

    logic        clk;
    logic        reset_n;
    logic        arm;
    logic [1:0]  mode;
    logic [15:0] trig_pc;
    logic        decode_valid;
    logic [15:0] decode_pc;
    logic [15:0] decode_instr;
    logic        decode_known;
    logic        exec_valid;
    logic [15:0] exec_result;
    logic        rd_en;
    logic [1:0]  rd_idx;
    logic        rd_valid;
    logic [15:0] rd_pc;
    logic [15:0] rd_instr;
    logic [15:0] rd_result;
    logic [2:0]  fill_count;
    logic [31:0] instr_count;
    logic        triggered;
    logic        halt_req;
    logic [1:0]  state_o;

    int n_tests = 0;
    int n_fail  = 0;

    pdp11_trace_buffer #(
        .DEPTH(4), .PC_W(16), .INS_W(16), .DATA_W(16), .POST_TRIG(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .arm(arm), .mode(mode), .trig_pc(trig_pc),
        .decode_valid(decode_valid), .decode_pc(decode_pc),
        .decode_instr(decode_instr), .decode_known(decode_known),
        .exec_valid(exec_valid), .exec_result(exec_result),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_pc(rd_pc),
        .rd_instr(rd_instr), .rd_result(rd_result), .fill_count(fill_count),
        .instr_count(instr_count), .triggered(triggered), .halt_req(halt_req),
        .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [1:0] m);
        mode = m;
        arm  = 1'b1;
        tick();
        arm  = 1'b0;
    endtask

    task automatic dec(input logic [15:0] pc, input logic [15:0] ins, input logic known);
        decode_valid = 1'b1;
        decode_pc    = pc;
        decode_instr = ins;
        decode_known = known;
        tick();
        decode_valid = 1'b0;
        decode_known = 1'b1;
    endtask

    task automatic exe(input logic [15:0] res);
        exec_valid  = 1'b1;
        exec_result = res;
        tick();
        exec_valid  = 1'b0;
    endtask

    task automatic pair(input logic [15:0] pc, input logic [15:0] res);
        dec(pc, KNOWN, 1'b1);
        exe(res);
    endtask

    task automatic rd(input int idx);
        rd_en  = 1'b1;
        rd_idx = 2'(idx);
        tick();
        rd_en  = 1'b0;
    endtask

    task automatic check_rec(input string tag, input logic [15:0] pc,
                             input logic [15:0] ins, input logic [15:0] res);
        check({tag, ".valid"}, 64'(rd_valid), 64'(1));
        check({tag, ".pc"}, 64'(rd_pc), 64'(pc));
        check({tag, ".instr"}, 64'(rd_instr), 64'(ins));
        check({tag, ".result"}, 64'(rd_result), 64'(res));
    endtask

    initial begin
        reset_n = 1'b0; arm = 1'b0; mode = 2'd0; trig_pc = '0;
        decode_valid = 1'b0; decode_pc = '0; decode_instr = '0; decode_known = 1'b1;
        exec_valid = 1'b0; exec_result = '0; rd_en = 1'b0; rd_idx = '0;
        tick(); tick();
        check("rst.state", 64'(state_o), 64'(0));
        check("rst.fill", 64'(fill_count), 64'(0));
        check("rst.icnt", 64'(instr_count), 64'(0));
        check("rst.halt", 64'(halt_req), 64'(0));
        check("rst.trig", 64'(triggered), 64'(0));
        check("rst.rdv", 64'(rd_valid), 64'(0));
        reset_n = 1'b1;
        tick();

        // 1: stop-when-full
        do_arm(2'd1);
        check("t1.state_cap", 64'(state_o), 64'(1));
        for (int i = 0; i < 6; i++) pair(16'(16'o1000 + 2 * i), 16'(16'h100 + i));
        check("t1.state", 64'(state_o), 64'(3));
        check("t1.fill", 64'(fill_count), 64'(4));
        check("t1.icnt", 64'(instr_count), 64'(4));
        for (int i = 0; i < 4; i++) begin
            rd(i);
            check_rec($sformatf("t1.rd%0d", i), 16'(16'o1000 + 2 * i), KNOWN, 16'(16'h100 + i));
        end

        // 2: free-run wrap, then halt on unknown instruction
        do_arm(2'd0);
        check("t2.fill0", 64'(fill_count), 64'(0));
        for (int i = 0; i < 10; i++) pair(16'(16'o1000 + 2 * i), 16'(16'h100 + i));
        check("t2.state_cap", 64'(state_o), 64'(1));
        check("t2.halt0", 64'(halt_req), 64'(0));
        dec(16'o2000, BAD, 1'b0);
        check("t2.halt", 64'(halt_req), 64'(1));
        check("t2.state", 64'(state_o), 64'(3));
        check("t2.fill", 64'(fill_count), 64'(4));
        check("t2.icnt", 64'(instr_count), 64'(11));
        rd(3);
        check_rec("t2.rd3", 16'o2000, BAD, 16'h0);
        rd(0);
        check_rec("t2.rd0", 16'o1016, KNOWN, 16'h107);

        // 3: PC trigger with two post-trigger records
        trig_pc = 16'o1010;
        do_arm(2'd2);
        check("t3.halt_clr", 64'(halt_req), 64'(0));
        check("t3.trig0", 64'(triggered), 64'(0));
        for (int i = 0; i < 10; i++) pair(16'(16'o1000 + 2 * i), 16'(16'h100 + i));
        check("t3.trig", 64'(triggered), 64'(1));
        check("t3.state", 64'(state_o), 64'(3));
        check("t3.icnt", 64'(instr_count), 64'(7));
        rd(3);
        check_rec("t3.rd3", 16'o1014, KNOWN, 16'h106);
        rd(0);
        check_rec("t3.rd0", 16'o1006, KNOWN, 16'h103);

        // 4: decode and exec in the same cycle
        do_arm(2'd0);
        dec(16'o1002, KNOWN, 1'b1);
        decode_valid = 1'b1; decode_pc = 16'o1004; decode_instr = 16'o005000; decode_known = 1'b1;
        exec_valid = 1'b1; exec_result = 16'd7;
        tick();
        decode_valid = 1'b0; exec_valid = 1'b0;
        check("t4.icnt1", 64'(instr_count), 64'(1));
        exe(16'd9);
        check("t4.icnt2", 64'(instr_count), 64'(2));
        dec(16'o3000, BAD, 1'b0);
        check("t4.fill", 64'(fill_count), 64'(3));
        rd(0);
        check_rec("t4.rd0", 16'o1002, KNOWN, 16'd7);
        rd(1);
        check_rec("t4.rd1", 16'o1004, 16'o005000, 16'd9);
        rd(2);
        check_rec("t4.rd2", 16'o3000, BAD, 16'd0);
        rd(3);
        check_rec("t4.rd3_empty", 16'd0, 16'd0, 16'd0);

        // 5: reset in the middle of POST
        trig_pc = 16'o1004;
        do_arm(2'd2);
        pair(16'o1000, 16'd1);
        pair(16'o1002, 16'd2);
        pair(16'o1004, 16'd3);
        check("t5.state_post", 64'(state_o), 64'(2));
        check("t5.trig", 64'(triggered), 64'(1));
        rd(0);
        check("t5.rdv_notfrozen", 64'(rd_valid), 64'(0));
        dec(16'o1006, KNOWN, 1'b1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t5.state", 64'(state_o), 64'(0));
        check("t5.fill", 64'(fill_count), 64'(0));
        check("t5.icnt", 64'(instr_count), 64'(0));
        check("t5.trig0", 64'(triggered), 64'(0));
        check("t5.halt", 64'(halt_req), 64'(0));
        check("t5.rdpc", 64'(rd_pc), 64'(0));
        do_arm(2'd0);
        check("t5.rearm_state", 64'(state_o), 64'(1));
        check("t5.rearm_fill", 64'(fill_count), 64'(0));

        // 6: exec with nothing pending, unknown opcode at PC 0
        exe(16'd4);
        check("t6.orphan_icnt", 64'(instr_count), 64'(0));
        dec(16'o0, BAD, 1'b0);
        check("t6.pc0_halt", 64'(halt_req), 64'(0));
        check("t6.pc0_state", 64'(state_o), 64'(1));
        exe(16'd5);
        check("t6.icnt", 64'(instr_count), 64'(1));
        check("t6.fill", 64'(fill_count), 64'(1));
        dec(16'o4000, BAD, 1'b0);
        check("t6.halt", 64'(halt_req), 64'(1));
        rd(0);
        check_rec("t6.rd0", 16'o0, BAD, 16'd5);
        rd(1);
        check_rec("t6.rd1", 16'o4000, BAD, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
